// File: rtl/score_step_driver.sv
// Step-pulse initiator for the chained BCD digit counters, with a BCD mirror of the chain value.
// Optional SCORE_STEP_SAT_EN: saturate at all-9s / zero instead of wrapping.
module score_step_driver #(
  parameter int DIGITS = 2,
  parameter int AW     = 8,
  parameter int GAP    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  dir,
  input  logic [AW-1:0]         amount,
  output logic                  ack,
  output logic                  busy,
  output logic                  up,
  output logic                  down,
  output logic                  done,
  output logic [4*DIGITS-1:0]   value
);

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_NULL, S_PULSE, S_GAP} state_t;

  state_t              state;
  logic                dir_q;
  logic [AW-1:0]       remaining;
  logic [GW-1:0]       gcnt;
  logic [4*DIGITS-1:0] val_inc;
  logic [4*DIGITS-1:0] val_dec;
  logic                cy;
  logic                bw;
  logic [3:0]          d;
  logic                pulse_dir;
  logic                sat_now;

  // Ripple BCD +1 / -1 over all digits; all-9s and all-0s wrap.
  always_comb begin
    val_inc = value;
    val_dec = value;
    cy      = 1'b1;
    bw      = 1'b1;
    d       = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      d = value[4*i +: 4];
      if (cy) begin
        if (d == 4'd9) val_inc[4*i +: 4] = 4'd0;
        else begin
          val_inc[4*i +: 4] = d + 4'd1;
          cy = 1'b0;
        end
      end
      if (bw) begin
        if (d == 4'd0) val_dec[4*i +: 4] = 4'd9;
        else begin
          val_dec[4*i +: 4] = d - 4'd1;
          bw = 1'b0;
        end
      end
    end
  end

  // Direction of the pulse about to be launched: fresh input on acceptance, latched otherwise.
  assign pulse_dir = (state == S_IDLE) ? dir : dir_q;

`ifdef SCORE_STEP_SAT_EN
  localparam logic [4*DIGITS-1:0] ALL9 = {DIGITS{4'h9}};
  assign sat_now = pulse_dir ? (value == ALL9) : (value == '0);
`else
  assign sat_now = 1'b0;
`endif

  // Outputs are registered alongside the state they belong to, so each output
  // is high exactly during the cycle its state is current.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      dir_q     <= 1'b0;
      remaining <= '0;
      gcnt      <= '0;
      value     <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ack  <= 1'b0;
      up   <= 1'b0;
      down <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            dir_q     <= dir;
            remaining <= amount;
            ack       <= 1'b1;
            busy      <= 1'b1;
            if (amount == '0) begin
              state <= S_NULL;
              done  <= 1'b1;
            end else begin
              state <= S_PULSE;
              up    <= pulse_dir & ~sat_now;
              down  <= ~pulse_dir & ~sat_now;
              done  <= (amount == AW'(1)) | sat_now;
            end
          end
        end
        S_NULL: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        S_PULSE: begin
          if (up)   value <= val_inc;
          if (down) value <= val_dec;
          // done here also covers a suppressed (saturated) pulse, which ends the request.
          remaining <= done ? '0 : remaining - AW'(1);
          gcnt      <= GAP_LAST;
          state     <= S_GAP;
        end
        default: begin
          if (gcnt != '0) begin
            gcnt <= gcnt - GW'(1);
          end else if (remaining != '0) begin
            state <= S_PULSE;
            up    <= pulse_dir & ~sat_now;
            down  <= ~pulse_dir & ~sat_now;
            done  <= (remaining == AW'(1)) | sat_now;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_score_step_driver.sv
// Directed bench for score_step_driver: table of step requests plus hand sequences for
// held REQ and mid-request reset.
module tb_score_step_driver;

  localparam int G = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       dir = 1'b0;
  logic [7:0] amount = 8'd0;
  logic       ack, busy, up, down, done;
  logic [7:0] value;

  int ncmp = 0;
  int nbad = 0;

  int ack_cyc, ack2_cyc, n_ack, n_up, n_down, n_done, done_cyc, idle_cyc;
  int pc[$];

  score_step_driver #(.DIGITS(2), .AW(8), .GAP(G)) dut (
    .clock(clk), .reset(reset), .req(req), .dir(dir), .amount(amount),
    .ack(ack), .busy(busy), .up(up), .down(down), .done(done), .value(value)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;   // reset before this request
    bit         d;
    int         amt;
    int         np;    // UP/DOWN pulses actually emitted
    int         ps;    // PULSE states visited
    logic [7:0] val;   // VALUE afterwards
  } vec_t;

  vec_t tv[11];

  task automatic chk(input string name, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #1;
    reset = 1'b1;
    req   = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issues one request starting in an IDLE cycle (cycle 0) and logs per-cycle outputs.
  task automatic run_req(input bit d_i, input logic [7:0] a_i, input bit hold);
    pc.delete();
    ack_cyc = -1; ack2_cyc = -1; done_cyc = -1; idle_cyc = -1;
    n_ack = 0; n_up = 0; n_down = 0; n_done = 0;
    @(posedge clk); #1;
    req = 1'b1; dir = d_i; amount = a_i;
    for (int c = 1; c <= 600; c++) begin
      @(posedge clk); #1;
      if (ack) begin
        n_ack++;
        if (ack_cyc < 0) ack_cyc = c;
        else if (ack2_cyc < 0) ack2_cyc = c;
      end
      if (up || down) pc.push_back(c);
      if (up) n_up++;
      if (down) n_down++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (!busy && idle_cyc < 0) idle_cyc = c;
      if (!hold && ack) req = 1'b0;
      if (hold && ack2_cyc > 0) req = 1'b0;
      if (!hold && idle_cyc > 0) break;
      if (hold && ack2_cyc > 0) break;
    end
    req = 1'b0;
  endtask

  task automatic wait_idle;
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      @(posedge clk); #1;
    end
    chk("drain_busy", busy, 0);
  endtask

  initial begin
    int xd, xi;
    tv[0]  = '{0, 1, 3,  3,  3,  8'h03};
    tv[1]  = '{0, 1, 39, 39, 39, 8'h42};
    tv[2]  = '{0, 1, 0,  0,  0,  8'h42};
    tv[3]  = '{0, 1, 56, 56, 56, 8'h98};
`ifdef SCORE_STEP_SAT_EN
    tv[4]  = '{0, 1, 3,  1,  2,  8'h99};
`else
    tv[4]  = '{0, 1, 3,  3,  3,  8'h01};
`endif
    tv[5]  = '{1, 1, 10, 10, 10, 8'h10};
    tv[6]  = '{0, 0, 1,  1,  1,  8'h09};
    tv[7]  = '{0, 0, 9,  9,  9,  8'h00};
`ifdef SCORE_STEP_SAT_EN
    tv[8]  = '{0, 0, 1,  0,  1,  8'h00};
    tv[9]  = '{0, 1, 2,  2,  2,  8'h02};
    tv[10] = '{0, 0, 0,  0,  0,  8'h02};
`else
    tv[8]  = '{0, 0, 1,  1,  1,  8'h99};
    tv[9]  = '{0, 1, 2,  2,  2,  8'h01};
    tv[10] = '{0, 0, 0,  0,  0,  8'h01};
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_up", up, 0);
    chk("rst_down", down, 0);
    chk("rst_done", done, 0);
    chk("rst_value", value, 0);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      run_req(tv[i].d, 8'(tv[i].amt), 1'b0);
      xd = (tv[i].ps == 0) ? 1 : 1 + (tv[i].ps - 1) * (G + 1);
      xi = (tv[i].ps == 0) ? 2 : 1 + tv[i].ps * (G + 1);
      chk($sformatf("v%0d_ack_cyc", i), ack_cyc, 1);
      chk($sformatf("v%0d_n_ack", i), n_ack, 1);
      chk($sformatf("v%0d_n_done", i), n_done, 1);
      chk($sformatf("v%0d_done_cyc", i), done_cyc, xd);
      chk($sformatf("v%0d_idle_cyc", i), idle_cyc, xi);
      chk($sformatf("v%0d_pulses", i), n_up + n_down, tv[i].np);
      chk($sformatf("v%0d_wrong_dir", i), tv[i].d ? n_down : n_up, 0);
      foreach (pc[k])
        chk($sformatf("v%0d_pulse%0d_cyc", i, k + 1), pc[k], 1 + k * (G + 1));
      chk($sformatf("v%0d_value", i), value, tv[i].val);
    end

    // Held REQ across a 2-step request: re-accepted only in the first IDLE cycle
    do_reset();
    run_req(1'b1, 8'd2, 1'b1);
    chk("hold_ack1_cyc", ack_cyc, 1);
    chk("hold_idle_cyc", idle_cyc, 5);
    chk("hold_ack2_cyc", ack2_cyc, 6);
    chk("hold_n_ack", n_ack, 2);
    wait_idle();
    chk("hold_value", value, 8'h04);

    // Reset in the GAP after pulse 1 of a 5-step request
    @(posedge clk); #1;
    req = 1'b1; dir = 1'b1; amount = 8'd5;
    @(posedge clk); #1;
    chk("mid_up1", up, 1);
    req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack", ack, 0);
    chk("mid_busy", busy, 0);
    chk("mid_up", up, 0);
    chk("mid_down", down, 0);
    chk("mid_done", done, 0);
    chk("mid_value", value, 0);
    reset = 1'b0;
    n_up = 0; n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (up) n_up++;
      if (done) n_done++;
    end
    chk("mid_no_up", n_up, 0);
    chk("mid_no_done", n_done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/score_step_driver.md
# score_step_driver

Step-pulse initiator for the chained decimal digit counters in the score display path. It accepts a signed step request (direction plus magnitude) through a REQ/ACK handshake. It then emits the matching number of single-cycle UP or DOWN pulses into the least-significant digit counter, spaced so each digit's carry/borrow cycle completes. It also keeps a BCD mirror of the counter chain's value so the game logic can read the score without tapping the digit outputs.

## Interface
- DIGITS, default 2: number of BCD digits mirrored; mirror range 0 .. 10^DIGITS-1.
- AW, default 8: width of AMOUNT (step count).
- GAP, default 1: idle cycles inserted after every pulse; legal range is GAP ≥ 1.

- CLOCK  in  1  sole clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  1  step request valid; requester holds it until ACK.
- DIR  in  1  1 = count up, 0 = count down; sampled with REQ.
- AMOUNT  in  AW  number of steps; sampled with REQ.
- ACK  out  1  one-cycle pulse: request accepted.
- BUSY  out  1  high whenever state ≠ IDLE.
- UP  out  1  one-cycle increment pulse to digit 0.
- DOWN  out  1  one-cycle decrement pulse to digit 0.
- DONE  out  1  one-cycle pulse: request finished.
- VALUE  out  4*DIGITS  BCD mirror of the chain; digit 0 is in [3:0].

## Operation
- **States:** IDLE, NULL, PULSE, GAP. All outputs are Moore-decoded from registered state and counters.
- **IDLE:**
  - REQ is sampled only in IDLE. On acceptance, DIR and AMOUNT are latched; remaining = AMOUNT.
  - AMOUNT = 0 → NULL.
  - AMOUNT > 0 → PULSE.
- **NULL:** ACK = 1 and DONE = 1, with no UP or DOWN. Next state is IDLE.
- **PULSE:**
  - Exactly one of UP/DOWN is asserted, per the latched DIR.
  - ACK = 1 on the first PULSE of a request only.
  - DONE = 1 when remaining = 1.
  - remaining decrements and VALUE updates.
  - Next state is always GAP.
- **GAP:** Hold for GAP cycles. Then go to PULSE if remaining > 0, else IDLE.
- **REQ during BUSY:** Not sampled and never acknowledged. A held REQ is accepted on the first IDLE cycle.
- **VALUE arithmetic:**
  - Per-digit BCD increment/decrement with ripple carry/borrow: a digit 9→0 carries, 0→9 borrows.
  - Without saturation: all-9s + 1 wraps to all-0s; all-0s − 1 wraps to all-9s. This matches the digit counter chain.
- **Pulse spacing:** The minimum spacing between pulses is GAP+1 cycles. This covers the digit counters' one-cycle carry state, which ignores UP/DOWN.
- **Reset:** Any cycle with RESET high leaves the following state as:
  - state = IDLE, remaining = 0, VALUE = 0.
  - ACK, BUSY, UP, DOWN and DONE all 0.
  - This applies mid-request: no further pulses are emitted and no DONE is issued.

## Timing
- Cycle 0 is the cycle in which REQ is sampled high in IDLE.
- **AMOUNT = n > 0:**
  - Pulse k (k = 1..n) occurs in cycle 1 + (k−1)(GAP+1).
  - ACK occurs in cycle 1.
  - DONE coincides with pulse n.
  - BUSY is high from cycle 1 through the end of the final GAP.
- **AMOUNT = 0:** ACK and DONE occur together in cycle 1.
- **Next request:** The earliest next acceptance is the first IDLE cycle after the final GAP.
- **VALUE:** Reflects each step in the cycle after its pulse.

## Configuration
- **Macro:** SCORE_STEP_SAT_EN.
- **Defined:** Saturating mirror and chain.
  - Applies in a PULSE cycle where DIR = 1 and VALUE = all-9s, or DIR = 0 and VALUE = 0.
  - UP/DOWN is suppressed and VALUE is unchanged.
  - remaining is forced to 0 and DONE = 1, plus ACK if this is the first PULSE.
  - The normal GAP → IDLE sequence then follows.
- **Not defined:** Modular wrap as described under Operation; no suppression logic is compiled in.

## Test plan
1. Reset; REQ with DIR=1, AMOUNT=3, GAP=1 → ACK+UP in cycle 1; UP in cycles 3 and 5 with DONE in 5; VALUE=0x03; BUSY low in cycle 7.
2. REQ with AMOUNT=0 at VALUE=0x42 → ACK and DONE in cycle 1; UP=DOWN=0 throughout; VALUE stays 0x42.
3. VALUE=0x98; DIR=1, AMOUNT=3:
   - Without the macro → three UP pulses, VALUE=0x01.
   - With SCORE_STEP_SAT_EN → one UP pulse (0x99); the second PULSE is suppressed with DONE; VALUE=0x99.
4. VALUE=0x10; DIR=0, AMOUNT=1 → one DOWN pulse with ACK+DONE; VALUE=0x09. VALUE=0x00 with DOWN, no macro → VALUE=0x99.
5. Hold REQ high continuously during a 2-step request → no second ACK while BUSY; the new request is accepted in the first IDLE cycle, and its ACK follows one cycle later.
6. RESET during GAP after pulse 1 of an AMOUNT=5 request → next cycle: all outputs 0, VALUE=0x00; no further UP; no DONE.
